moore_seq_tx: RTL
=================

MOORE_SEQ_TX -- requirements
Module: moore_seq_tx

Interface
REQ-001 The block SHALL have one parameter: PAT_W, default 4, pattern length in bits (2..16).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to begin a transmission; sampled on rising clk.
REQ-006 pattern  input  PAT_W  bit pattern to serialize, MSB sent first.
REQ-007 reps  input  4  number of frames to send (0..15).
REQ-008 gap  input  2  number of idle bit times inserted between consecutive frames (0..3).
REQ-009 x  output  1  serial data bit, intended to drive a sequence detector's x input.
REQ-010 x_valid  output  1  high when x carries a pattern bit.
REQ-011 busy  output  1  high while a transmission is in progress.
REQ-012 done  output  1  one-cycle pulse after the last bit of the last frame.
REQ-013 frame_cnt  output  4  number of frames fully sent in the current or most recent transmission.

Function
REQ-014 All outputs SHALL be registered (Moore); no combinational path from any input to any output.
REQ-015 The FSM SHALL have four states: IDLE, SHIFT, GAP, DONE.
REQ-016 IDLE: x=0, x_valid=0, busy=0, done=0; start=1 with reps!=0 -> SHIFT; otherwise stay.
REQ-017 start with reps=0 SHALL be ignored (no busy, no done, frame_cnt unchanged).
REQ-018 On an accepted start, pattern, reps and gap SHALL be latched; frame_cnt SHALL clear to 0.
REQ-019 Latency: start accepted at edge N -> first pattern bit (pattern[PAT_W-1]) on x with x_valid=1 from edge N+1.
REQ-020 SHIFT: one bit per cycle, MSB first, x_valid=1, busy=1; bit index counter counts 0..PAT_W-1.
REQ-021 At the last bit of a frame, frame_cnt SHALL increment on the edge that leaves SHIFT.
REQ-022 After the last bit: frames remaining and gap!=0 -> GAP; frames remaining and gap=0 -> SHIFT (next frame's MSB in the immediately following cycle, no bubble); no frames remaining -> DONE.
REQ-023 GAP: x=0, x_valid=0, busy=1 for exactly gap cycles, then SHIFT.
REQ-024 DONE: done=1, busy=0, x=0, x_valid=0 for exactly one cycle, then IDLE.
REQ-025 Total busy cycles SHALL equal reps*PAT_W + (reps-1)*gap.
REQ-026 start while busy or in DONE SHALL be ignored; changes on pattern/reps/gap while busy SHALL have no effect.
REQ-027 start in the cycle after DONE (in IDLE) SHALL be accepted normally.
REQ-028 frame_cnt SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-029 Asserting reset SHALL immediately (without clock) force state IDLE and x=0, x_valid=0, busy=0, done=0, frame_cnt=0, internal counters and latched registers 0.
REQ-030 Reset asserted mid-frame SHALL abort the transmission; no done pulse SHALL follow.
REQ-031 After reset deasserts, the first rising edge with start=1 and reps!=0 SHALL be accepted.

Verification
REQ-032 PAT_W=4, pattern=0110, reps=1, gap=0, start 1 cycle -> x=0,1,1,0 with x_valid=1 for 4 cycles, done=1 on 5th cycle, frame_cnt=1.
REQ-033 pattern=0110, reps=3, gap=0 -> 12 contiguous valid bits 011001100110 (detector with overlap sees three 0110), done on cycle 13, frame_cnt=3.
REQ-034 pattern=0110, reps=2, gap=2 -> 0110, two cycles x=0/x_valid=0, 0110; busy high 10 cycles; done on cycle 11.
REQ-035 start with reps=0 -> busy, x_valid, done stay 0; frame_cnt unchanged.
REQ-036 reps=2, gap=0, reset asserted mid-clock during bit 2 of frame 1 -> all outputs 0 immediately, no done; new start after release transmits normally.
REQ-037 During a reps=2 transmission, pulse start and change pattern to 1001 -> ignored; output remains 01100110, single done pulse.

Source files
------------

// File: rtl/moore_seq_tx.sv
// ---------------------------------------------------------------------------
// moore_seq_tx
//
// Serial pattern transmitter that feeds a sequence detector. On an accepted
// start it sends `reps` frames of `pattern` (MSB first, one bit per clock).
// Consecutive frames are separated by `gap` idle bit times. Every output is a
// flop that is decoded from the current state, so no input reaches an output
// combinationally. For the same reason the outputs trail the state register
// by one clock.
//
// Parameters
//   PAT_W      pattern length in bits (2..16)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   begin a transmission (ignored unless idle and reps != 0)
//   pattern    in   [PAT_W] bits to serialize, MSB first
//   reps       in   [4] number of frames (0 = request ignored)
//   gap        in   [2] idle bit times between frames
//   x          out  serial data bit
//   x_valid    out  x carries a pattern bit
//   busy       out  transmission in progress
//   done       out  one-cycle pulse after the last bit of the last frame
//   frame_cnt  out  [4] frames fully sent in the current/most recent run
// ---------------------------------------------------------------------------
module moore_seq_tx #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       reps,
    input  logic [1:0]       gap,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [3:0]       frame_cnt
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [PAT_W-1:0]   pat_q,       pat_d;
    logic [1:0]         gap_q,       gap_d;
    logic [3:0]         reps_left_q, reps_left_d;
    logic [IDX_W-1:0]   bit_idx_q,   bit_idx_d;
    logic [1:0]         gap_cnt_q,   gap_cnt_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;

    logic x_q,       x_d;
    logic x_valid_q, x_valid_d;
    logic busy_q,    busy_d;
    logic done_q,    done_d;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, matching hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            gap_q       <= '0;
            reps_left_q <= '0;
            bit_idx_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            gap_q       <= gap_d;
            reps_left_q <= reps_left_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        gap_d       = gap_q;
        reps_left_d = reps_left_q;
        bit_idx_d   = bit_idx_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                // The state machine reaches IDLE one clock before the
                // registered done pulse is visible. Holding off while done_q
                // is high makes a start that arrives during the pulse ignored,
                // as seen from the pins.
                if (start && (reps != 4'd0) && !done_q) begin
                    state_d     = SHIFT;
                    pat_d       = pattern;
                    gap_d       = gap;
                    reps_left_d = reps;
                    bit_idx_d   = '0;
                    gap_cnt_d   = '0;
                    frame_cnt_d = '0;
                end
            end

            SHIFT: begin
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d   = '0;
                    frame_cnt_d = frame_cnt_q + 4'd1;
                    reps_left_d = reps_left_q - 4'd1;
                    if (reps_left_q == 4'd1) begin
                        state_d = DONE;
                    end else if (gap_q != 2'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        state_d = SHIFT;   // back-to-back frame, no bubble
                    end
                end else begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end

            GAP: begin
                gap_cnt_d = gap_cnt_q - 2'd1;
                if (gap_cnt_q == 2'd1) begin
                    state_d = SHIFT;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered in the state process above)
    // -----------------------------------------------------------------------
    always_comb begin
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            SHIFT: begin
                x_d       = pat_q[LAST_IDX - bit_idx_q];
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            GAP: begin
                busy_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                x_d = 1'b0;
            end
        endcase
    end

    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule
